// File: rtl/decoder_pkg.sv
// Shared types and helpers for the strobe/select decoder family.
// Holds the FSM state encoding and the pulse-counter width helper.
package decoder_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      PULSE = 1'b1
   } state_t;

   // Wide enough to hold PULSE_LEN-1 without wrapping, and never zero width.
   function automatic int cnt_width(input int pulse_len);
      return (pulse_len < 1) ? 1 : $clog2(pulse_len + 1);
   endfunction

endpackage

// File: rtl/onehot_dec.sv
// Combinational sel -> one-hot decoder with an in-range flag.
// Out-of-range indices produce an all-zero vector.
module onehot_dec
   import decoder_pkg::*;
#(
   parameter int SEL_W   = 3,
   parameter int NUM_OUT = 8
) (
   input  logic [SEL_W-1:0]   sel,
   output logic [NUM_OUT-1:0] onehot,
   output logic               in_range
);

   always_comb begin
      onehot   = '0;
      in_range = (int'(sel) < NUM_OUT);
      for (int i = 0; i < NUM_OUT; i++) begin
         onehot[i] = (int'(sel) == i);
      end
   end

endmodule

// File: rtl/decoder_strobe_gen.sv
// Registered one-hot decoder with valid/ready input, level and timed-pulse modes.
// Optional out-of-range error flag is built when DECODER_RANGE_CHK_EN is defined.
module decoder_strobe_gen
   import decoder_pkg::*;
#(
   parameter int SEL_W     = 3,
   parameter int NUM_OUT   = 8,
   parameter int PULSE_LEN = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [SEL_W-1:0]   sel,
   input  logic               sel_valid,
   output logic               sel_ready,
   input  logic               decoder_enable,
   input  logic               level_mode,
   output logic [NUM_OUT-1:0] out,
   output logic               busy,
   output logic               done
`ifdef DECODER_RANGE_CHK_EN
   ,output logic              err
`endif
);

   localparam int CNT_W = cnt_width(PULSE_LEN);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(PULSE_LEN - 1);

   state_t             state;
   logic [CNT_W-1:0]   cnt;
   logic [NUM_OUT-1:0] dec_vec;
   logic               in_range;
   logic               accept;

   onehot_dec #(
      .SEL_W   (SEL_W),
      .NUM_OUT (NUM_OUT)
   ) u_dec (
      .sel      (sel),
      .onehot   (dec_vec),
      .in_range (in_range)
   );

   // Ready is held low while reset is asserted so nothing is offered before release.
   assign sel_ready = rst_n & decoder_enable & (state == IDLE);
   assign accept    = sel_valid & sel_ready;
   assign busy      = (state == PULSE);

   // Enable-low abort is checked first so it beats a same-cycle pulse completion.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
         out   <= '0;
         done  <= 1'b0;
`ifdef DECODER_RANGE_CHK_EN
         err   <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
`ifdef DECODER_RANGE_CHK_EN
         err  <= 1'b0;
`endif
         if (!decoder_enable) begin
            out   <= '0;
            cnt   <= '0;
            state <= IDLE;
         end else if (state == PULSE) begin
            if (cnt != '0) begin
               cnt <= cnt - CNT_W'(1);
            end else begin
               out   <= '0;
               done  <= 1'b1;
               state <= IDLE;
            end
         end else if (accept) begin
            if (in_range) begin
               out <= dec_vec;
               if (!level_mode) begin
                  cnt   <= CNT_LOAD;
                  state <= PULSE;
               end
            end else begin
               out <= '0;
`ifdef DECODER_RANGE_CHK_EN
               err <= 1'b1;
`endif
            end
         end
      end
   end

endmodule

// File: tb/tb_decoder_strobe_gen.sv
// Self-checking bench for decoder_strobe_gen (SEL_W=3, NUM_OUT=6, PULSE_LEN=3).
// Expected per-cycle results are queued with each stimulus and popped after the edge.
module tb_decoder_strobe_gen;

   localparam int SEL_W     = 3;
   localparam int NUM_OUT   = 6;
   localparam int PULSE_LEN = 3;

   logic               clk;
   logic               rst_n;
   logic [SEL_W-1:0]   sel;
   logic               sel_valid;
   logic               sel_ready;
   logic               decoder_enable;
   logic               level_mode;
   logic [NUM_OUT-1:0] out;
   logic               busy;
   logic               done;
`ifdef DECODER_RANGE_CHK_EN
   logic               err;
`endif

   typedef struct packed {
      logic [NUM_OUT-1:0] out;
      logic               busy;
      logic               done;
      logic               ready;
      logic               err;
   } exp_t;

   exp_t exp_q[$];
   int   test_count = 0;
   int   fail_count = 0;

   decoder_strobe_gen #(
      .SEL_W     (SEL_W),
      .NUM_OUT   (NUM_OUT),
      .PULSE_LEN (PULSE_LEN)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .sel            (sel),
      .sel_valid      (sel_valid),
      .sel_ready      (sel_ready),
      .decoder_enable (decoder_enable),
      .level_mode     (level_mode),
      .out            (out),
      .busy           (busy),
      .done           (done)
`ifdef DECODER_RANGE_CHK_EN
      ,.err           (err)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      test_count++;
      if (observed !== expected) begin
         fail_count++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
      end
   endtask

   // Drive one cycle of inputs, queue what must be visible after the next edge, then compare.
   task automatic applyStimulus(input string tag, input logic en, input logic valid,
                                input logic lvl, input logic [SEL_W-1:0] s,
                                input logic [NUM_OUT-1:0] e_out, input logic e_busy,
                                input logic e_done, input logic e_ready, input logic e_err);
      exp_t ex;
      decoder_enable = en;
      sel_valid      = valid;
      level_mode     = lvl;
      sel            = s;
      exp_q.push_back('{out: e_out, busy: e_busy, done: e_done, ready: e_ready, err: e_err});
      @(posedge clk);
      #1;
      ex = exp_q.pop_front();
      checkOutput({tag, ".out"},   32'(out),       32'(ex.out));
      checkOutput({tag, ".busy"},  32'(busy),      32'(ex.busy));
      checkOutput({tag, ".done"},  32'(done),      32'(ex.done));
      checkOutput({tag, ".ready"}, 32'(sel_ready), 32'(ex.ready));
`ifdef DECODER_RANGE_CHK_EN
      checkOutput({tag, ".err"},   32'(err),       32'(ex.err));
`endif
   endtask

   initial begin
      rst_n          = 1'b0;
      decoder_enable = 1'b1;
      sel_valid      = 1'b0;
      level_mode     = 1'b0;
      sel            = '0;

      #12;
      checkOutput("rst.out",   32'(out),       32'h0);
      checkOutput("rst.busy",  32'(busy),      32'h0);
      checkOutput("rst.done",  32'(done),      32'h0);
      checkOutput("rst.ready", 32'(sel_ready), 32'h0);
`ifdef DECODER_RANGE_CHK_EN
      checkOutput("rst.err",   32'(err),       32'h0);
`endif
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("rel.ready", 32'(sel_ready), 32'h1);
      checkOutput("rel.out",   32'(out),       32'h0);

      // Level mode: sel=2, hold, then sel=5 with no zero gap, then enable low.
      applyStimulus("lvl_a",    1, 1, 1, 3'd2, 6'b000100, 0, 0, 1, 0);
      applyStimulus("lvl_hold", 1, 0, 1, 3'd0, 6'b000100, 0, 0, 1, 0);
      applyStimulus("lvl_b",    1, 1, 1, 3'd5, 6'b100000, 0, 0, 1, 0);
      applyStimulus("lvl_off",  0, 0, 1, 3'd0, 6'b000000, 0, 0, 0, 0);

      // Enable low with valid high: no accept.
      applyStimulus("noacc",    0, 1, 1, 3'd2, 6'b000000, 0, 0, 0, 0);
      applyStimulus("noacc2",   1, 0, 1, 3'd0, 6'b000000, 0, 0, 1, 0);

      // Pulse mode sel=4 for 3 cycles, done, then immediate second pulse sel=1.
      applyStimulus("pls_a",    1, 1, 0, 3'd4, 6'b010000, 1, 0, 0, 0);
      applyStimulus("pls_a1",   1, 0, 0, 3'd0, 6'b010000, 1, 0, 0, 0);
      applyStimulus("pls_a2",   1, 0, 0, 3'd0, 6'b010000, 1, 0, 0, 0);
      applyStimulus("pls_adn",  1, 0, 0, 3'd0, 6'b000000, 0, 1, 1, 0);
      applyStimulus("pls_b",    1, 1, 0, 3'd1, 6'b000010, 1, 0, 0, 0);
      applyStimulus("pls_b1",   1, 0, 0, 3'd0, 6'b000010, 1, 0, 0, 0);
      applyStimulus("pls_b2",   1, 0, 0, 3'd0, 6'b000010, 1, 0, 0, 0);
      applyStimulus("pls_bdn",  1, 0, 0, 3'd0, 6'b000000, 0, 1, 1, 0);

      // Abort on the 2nd pulse cycle: no done afterwards.
      applyStimulus("abt",      1, 1, 0, 3'd3, 6'b001000, 1, 0, 0, 0);
      applyStimulus("abt1",     1, 0, 0, 3'd0, 6'b001000, 1, 0, 0, 0);
      applyStimulus("abt_off",  0, 0, 0, 3'd0, 6'b000000, 0, 0, 0, 0);
      applyStimulus("abt_idl",  1, 0, 0, 3'd0, 6'b000000, 0, 0, 1, 0);
      applyStimulus("abt_idl2", 1, 0, 0, 3'd0, 6'b000000, 0, 0, 1, 0);

      // Abort in the same cycle the pulse would have completed.
      applyStimulus("pri",      1, 1, 0, 3'd0, 6'b000001, 1, 0, 0, 0);
      applyStimulus("pri1",     1, 0, 0, 3'd0, 6'b000001, 1, 0, 0, 0);
      applyStimulus("pri2",     1, 0, 0, 3'd0, 6'b000001, 1, 0, 0, 0);
      applyStimulus("pri_off",  0, 0, 0, 3'd0, 6'b000000, 0, 0, 0, 0);
      applyStimulus("pri_idl",  1, 0, 0, 3'd0, 6'b000000, 0, 0, 1, 0);

      // Out of range while a level line is held.
      applyStimulus("oor_lvl",  1, 1, 1, 3'd1, 6'b000010, 0, 0, 1, 0);
      applyStimulus("oor",      1, 1, 1, 3'd7, 6'b000000, 0, 0, 1, 1);
      applyStimulus("oor1",     1, 0, 1, 3'd0, 6'b000000, 0, 0, 1, 0);
      applyStimulus("oor2",     1, 0, 1, 3'd0, 6'b000000, 0, 0, 1, 0);

      // Async reset asserted between edges during a pulse.
      applyStimulus("ar",       1, 1, 0, 3'd5, 6'b100000, 1, 0, 0, 0);
      #3;
      rst_n = 1'b0;
      #1;
      checkOutput("ar.out",   32'(out),  32'h0);
      checkOutput("ar.busy",  32'(busy), 32'h0);
      checkOutput("ar.done",  32'(done), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      applyStimulus("ar_rel",   1, 0, 0, 3'd0, 6'b000000, 0, 0, 1, 0);
      applyStimulus("ar_rel2",  1, 0, 0, 3'd0, 6'b000000, 0, 0, 1, 0);

      $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
      $finish;
   end

endmodule
